// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage RV32I pipeline.
// Muxes operand B, decodes ALUOp/funct3/funct7 into an ALU operation, and
// registers ALU_Result/Zero into the EX/MEM boundary with one cycle of latency.
// Optional feature macro: EXEC_MUL_EN adds the M-extension multiplies
// (MUL/MULH/MULHSU/MULHU) on R-type with funct7 = 0000001.
module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] reg_data1,
    input  logic [XLEN-1:0] reg_data2,
    input  logic [XLEN-1:0] imm,
    input  logic            select_imm,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [1:0]      ALUOp,
    output logic [XLEN-1:0] ALU_Result,
    output logic            Zero
);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_SLL    = 4'd2;
    localparam logic [3:0] OP_SLT    = 4'd3;
    localparam logic [3:0] OP_SLTU   = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_SRL    = 4'd6;
    localparam logic [3:0] OP_SRA    = 4'd7;
    localparam logic [3:0] OP_OR     = 4'd8;
    localparam logic [3:0] OP_AND    = 4'd9;
    localparam logic [3:0] OP_MUL    = 4'd10;
    localparam logic [3:0] OP_MULH   = 4'd11;
    localparam logic [3:0] OP_MULHSU = 4'd12;
    localparam logic [3:0] OP_MULHU  = 4'd13;
    localparam logic [3:0] OP_ZERO   = 4'd14;

    logic [XLEN-1:0] w_opb;
    logic [3:0]      w_op;
    logic [XLEN-1:0] w_result;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] r_alu_result;
    logic            r_zero;

    assign w_opb   = select_imm ? imm : reg_data2;
    assign w_shamt = w_opb[4:0];

`ifdef EXEC_MUL_EN
    logic            w_is_mul;
    logic [63:0]     w_mul_a;
    logic [63:0]     w_mul_b;
    logic [63:0]     w_prod;

    assign w_is_mul = (ALUOp == 2'b10) && (funct7 == 7'b0000001);

    // Extend operands to 64 bits per signedness; the truncated 64-bit product
    // is then correct for every MUL variant.
    always_comb begin
        w_mul_a = {32'd0, reg_data1};
        w_mul_b = {32'd0, w_opb};
        if (funct3 == 3'b001 || funct3 == 3'b010) begin
            w_mul_a = {{32{reg_data1[31]}}, reg_data1};
        end
        if (funct3 == 3'b001) begin
            w_mul_b = {{32{w_opb[31]}}, w_opb};
        end
    end

    assign w_prod = w_mul_a * w_mul_b;
`else
    logic w_is_mul;
    assign w_is_mul = 1'b0;
`endif

    // ALU control decode from ALUOp/funct3/funct7[5].
    always_comb begin
        w_op = OP_ADD;
        if (w_is_mul) begin
            case (funct3)
                3'b000:  w_op = OP_MUL;
                3'b001:  w_op = OP_MULH;
                3'b010:  w_op = OP_MULHSU;
                3'b011:  w_op = OP_MULHU;
                default: w_op = OP_ZERO;
            endcase
        end else begin
            case (ALUOp)
                2'b00: w_op = OP_ADD;
                2'b01: w_op = OP_SUB;
                default: begin
                    case (funct3)
                        3'b000:  w_op = (ALUOp == 2'b10 && funct7[5]) ? OP_SUB : OP_ADD;
                        3'b001:  w_op = OP_SLL;
                        3'b010:  w_op = OP_SLT;
                        3'b011:  w_op = OP_SLTU;
                        3'b100:  w_op = OP_XOR;
                        3'b101:  w_op = funct7[5] ? OP_SRA : OP_SRL;
                        3'b110:  w_op = OP_OR;
                        default: w_op = OP_AND;
                    endcase
                end
            endcase
        end
    end

    // ALU datapath: compute the result for the decoded operation.
    always_comb begin
        w_result = '0;
        case (w_op)
            OP_ADD:  w_result = reg_data1 + w_opb;
            OP_SUB:  w_result = reg_data1 - w_opb;
            OP_SLL:  w_result = reg_data1 << w_shamt;
            OP_SLT:  w_result = {31'd0, $signed(reg_data1) < $signed(w_opb)};
            OP_SLTU: w_result = {31'd0, reg_data1 < w_opb};
            OP_XOR:  w_result = reg_data1 ^ w_opb;
            OP_SRL:  w_result = reg_data1 >> w_shamt;
            OP_SRA:  w_result = $unsigned($signed(reg_data1) >>> w_shamt);
            OP_OR:   w_result = reg_data1 | w_opb;
            OP_AND:  w_result = reg_data1 & w_opb;
`ifdef EXEC_MUL_EN
            OP_MUL:    w_result = w_prod[31:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  w_result = w_prod[63:32];
`endif
            default: w_result = '0;
        endcase
    end

    // EX/MEM register: result and zero flag from the same value; sync active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_alu_result <= '0;
            r_zero       <= 1'b0;
        end else begin
            r_alu_result <= w_result;
            r_zero       <= (w_result == '0);
        end
    end

    assign ALU_Result = r_alu_result;
    assign Zero       = r_zero;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: table-driven directed vectors for execute_stage plus
// hand-written reset/latency sequences. Expected values are hand-computed.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] reg_data1;
    logic [31:0] reg_data2;
    logic [31:0] imm;
    logic        select_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [1:0]  ALUOp;
    logic [31:0] ALU_Result;
    logic        Zero;

    int n_chk  = 0;
    int n_fail = 0;

    execute_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_data1  (reg_data1),
        .reg_data2  (reg_data2),
        .imm        (imm),
        .select_imm (select_imm),
        .funct3     (funct3),
        .funct7     (funct7),
        .ALUOp      (ALUOp),
        .ALU_Result (ALU_Result),
        .Zero       (Zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] rd2;
        logic [31:0] im;
        logic        sel;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [1:0]  op;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [31:0] a, logic [31:0] rd2,
                                logic [31:0] im, logic sel, logic [2:0] f3,
                                logic [6:0] f7, logic [1:0] op,
                                logic [31:0] exp_res, logic exp_zero);
        vec_t v;
        v.name = name; v.a = a; v.rd2 = rd2; v.im = im; v.sel = sel;
        v.f3 = f3; v.f7 = f7; v.op = op; v.exp_res = exp_res; v.exp_zero = exp_zero;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] rd2, input logic [31:0] im,
                         input logic sel, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [1:0] op);
        reg_data1 = a; reg_data2 = rd2; imm = im; select_imm = sel;
        funct3 = f3; funct7 = f7; ALUOp = op;
    endtask

    initial begin
        // name, A, rd2, imm, sel, f3, f7, ALUOp, result, zero
        vecs.push_back(mk("r_add",    32'd10, 32'd20, 32'd100, 1'b0, 3'b000, 7'h00, 2'b10, 32'd30, 1'b0));
        vecs.push_back(mk("r_sub",    32'd10, 32'd20, 32'd100, 1'b0, 3'b000, 7'h20, 2'b10, 32'hFFFFFFF6, 1'b0));
        vecs.push_back(mk("r_and",    32'd10, 32'd20, 32'd100, 1'b0, 3'b111, 7'h00, 2'b10, 32'd0, 1'b1));
        vecs.push_back(mk("r_or",     32'd10, 32'd20, 32'd100, 1'b0, 3'b110, 7'h00, 2'b10, 32'd30, 1'b0));
        vecs.push_back(mk("r_xor",    32'd10, 32'd20, 32'd100, 1'b0, 3'b100, 7'h00, 2'b10, 32'd30, 1'b0));
        vecs.push_back(mk("imm_add",  32'd10, 32'd20, 32'd100, 1'b1, 3'b000, 7'h00, 2'b00, 32'd110, 1'b0));
        vecs.push_back(mk("slt",      32'hFFFFFFFB, 32'd20, 32'd4, 1'b1, 3'b010, 7'h00, 2'b10, 32'd1, 1'b0));
        vecs.push_back(mk("sltu",     32'hFFFFFFFB, 32'd20, 32'd4, 1'b1, 3'b011, 7'h00, 2'b10, 32'd0, 1'b1));
        vecs.push_back(mk("srai",     32'h80000000, 32'd0, 32'd4, 1'b1, 3'b101, 7'h20, 2'b11, 32'hF8000000, 1'b0));
        vecs.push_back(mk("srli",     32'h80000000, 32'd0, 32'd4, 1'b1, 3'b101, 7'h00, 2'b11, 32'h08000000, 1'b0));
        vecs.push_back(mk("slli",     32'd1, 32'd0, 32'd31, 1'b1, 3'b001, 7'h00, 2'b11, 32'h80000000, 1'b0));
        vecs.push_back(mk("addi_f7",  32'd10, 32'd0, 32'd3, 1'b1, 3'b000, 7'h20, 2'b11, 32'd13, 1'b0));
        vecs.push_back(mk("r_sra_b4", 32'hFFFFFF00, 32'h24, 32'd0, 1'b0, 3'b101, 7'h20, 2'b10, 32'hFFFFFFF0, 1'b0));
        vecs.push_back(mk("beq",      32'd7, 32'd7, 32'd99, 1'b0, 3'b000, 7'h00, 2'b01, 32'd0, 1'b1));
        vecs.push_back(mk("bne",      32'd7, 32'd8, 32'd99, 1'b0, 3'b001, 7'h20, 2'b01, 32'hFFFFFFFF, 1'b0));
        vecs.push_back(mk("add_wrap", 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 3'b111, 7'h20, 2'b00, 32'd0, 1'b1));
`ifdef EXEC_MUL_EN
        vecs.push_back(mk("mul",      32'hFFFFFFFD, 32'd5, 32'd0, 1'b0, 3'b000, 7'h01, 2'b10, 32'hFFFFFFF1, 1'b0));
        vecs.push_back(mk("mulh",     32'hFFFFFFFD, 32'd5, 32'd0, 1'b0, 3'b001, 7'h01, 2'b10, 32'hFFFFFFFF, 1'b0));
        vecs.push_back(mk("mulhsu",   32'hFFFFFFFD, 32'd5, 32'd0, 1'b0, 3'b010, 7'h01, 2'b10, 32'hFFFFFFFF, 1'b0));
        vecs.push_back(mk("mulhu",    32'hFFFFFFFD, 32'd5, 32'd0, 1'b0, 3'b011, 7'h01, 2'b10, 32'd4, 1'b0));
        vecs.push_back(mk("mul_f3hi", 32'hFFFFFFFD, 32'd5, 32'd0, 1'b0, 3'b110, 7'h01, 2'b10, 32'd0, 1'b1));
`else
        vecs.push_back(mk("f7_1_add", 32'hFFFFFFFD, 32'd5, 32'd0, 1'b0, 3'b000, 7'h01, 2'b10, 32'd2, 1'b0));
        vecs.push_back(mk("f7_1_sll", 32'hFFFFFFFD, 32'd5, 32'd0, 1'b0, 3'b001, 7'h01, 2'b10, 32'hFFFFFFA0, 1'b0));
        vecs.push_back(mk("f7_1_slt", 32'hFFFFFFFD, 32'd5, 32'd0, 1'b0, 3'b010, 7'h01, 2'b10, 32'd1, 1'b0));
        vecs.push_back(mk("f7_1_sltu",32'hFFFFFFFD, 32'd5, 32'd0, 1'b0, 3'b011, 7'h01, 2'b10, 32'd0, 1'b1));
        vecs.push_back(mk("f7_1_or",  32'hFFFFFFFD, 32'd5, 32'd0, 1'b0, 3'b110, 7'h01, 2'b10, 32'hFFFFFFFD, 1'b0));
`endif

        // Reset held for two edges with an op that would give 30.
        rst = 1'b0;
        drive(32'd10, 32'd20, 32'd100, 1'b0, 3'b000, 7'h00, 2'b10);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("reset_result", ALU_Result, 32'd0);
            chk("reset_zero", {31'd0, Zero}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_result", ALU_Result, 32'd30);
        chk("post_reset_zero", {31'd0, Zero}, 32'd0);

        // Table-driven vectors, one edge each.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].a, vecs[i].rd2, vecs[i].im, vecs[i].sel,
                  vecs[i].f3, vecs[i].f7, vecs[i].op);
            @(posedge clk); #1;
            chk({vecs[i].name, "_result"}, ALU_Result, vecs[i].exp_res);
            chk({vecs[i].name, "_zero"}, {31'd0, Zero}, {31'd0, vecs[i].exp_zero});
        end

        // Latency: new inputs must not reach the output before the next edge.
        @(negedge clk);
        drive(32'd10, 32'd20, 32'd100, 1'b0, 3'b000, 7'h00, 2'b10);
        @(posedge clk); #1;
        chk("lat_a", ALU_Result, 32'd30);
        @(negedge clk);
        drive(32'd1, 32'd2, 32'd0, 1'b0, 3'b000, 7'h00, 2'b10);
        #2;
        chk("lat_hold", ALU_Result, 32'd30);
        @(posedge clk); #1;
        chk("lat_b", ALU_Result, 32'd3);

        // Mid-stream reset with an op whose result is zero: Zero must stay 0.
        @(negedge clk);
        rst = 1'b0;
        drive(32'd10, 32'd20, 32'd0, 1'b0, 3'b111, 7'h00, 2'b10);
        @(posedge clk); #1;
        chk("mid_reset_result", ALU_Result, 32'd0);
        chk("mid_reset_zero", {31'd0, Zero}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("after_mid_reset_result", ALU_Result, 32'd0);
        chk("after_mid_reset_zero", {31'd0, Zero}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (EX) stage of the 5-stage RV32I pipeline.
- Selects the second ALU operand (register or immediate) and decodes ALUOp/funct3/funct7 into an ALU operation.
- Computes the result and registers ALU_Result and Zero into the EX/MEM boundary, one clock after the operands are presented.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- reg_data1  input  XLEN  operand A (rs1 value).
- reg_data2  input  XLEN  rs2 value; operand B candidate.
- imm  input  XLEN  sign-extended immediate; operand B candidate.
- select_imm  input  1  operand-B mux select: 0 = reg_data2, 1 = imm.
- funct3  input  3  instruction funct3.
- funct7  input  7  instruction funct7.
- ALUOp  input  2  main-decoder class: 00 add, 01 branch compare, 10 R-type, 11 I-type ALU.
- ALU_Result  output  XLEN  registered ALU result.
- Zero  output  1  registered flag, 1 when the result is all zeros.

Behaviour:
- Operand B is a combinational mux: B = select_imm ? imm : reg_data2. The mux and the decode are independent; select_imm never alters the decode.
- ALU control decode (combinational):
  - ALUOp 00 -> ADD, regardless of funct3/funct7. Used for loads, stores, ADDI-style address/adds.
  - ALUOp 01 -> SUB (branch comparison).
  - ALUOp 10, R-type, by funct3:
    - 000 -> ADD if funct7[5]=0, SUB if funct7[5]=1.
    - 001 SLL; 010 SLT; 011 SLTU; 100 XOR.
    - 101 -> SRL if funct7[5]=0, SRA if funct7[5]=1.
    - 110 OR; 111 AND.
  - ALUOp 11, I-type: same funct3 map, except 000 is always ADD (funct7 ignored). For 101, funct7[5] selects SRAI vs SRLI.
  - Only funct7[5] is examined; all other funct7 bits are ignored in the base configuration.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^32; no overflow flag.
  - Shift amount = B[4:0]. SRA sign-fills from A[31].
  - SLT: signed compare. SLTU: unsigned compare. Both produce 32'd0 or 32'd1.
- Latency: 1 cycle. Inputs stable before rising edge N appear on ALU_Result/Zero after edge N.
- Zero = (computed result == 0). It is computed from the same value being registered, so it is always consistent with ALU_Result.
- Reset: when rst=0 at a rising edge, ALU_Result <= 0 and Zero <= 0, overriding any operation in flight.
  - The first edge with rst=1 registers the current inputs normally.
  - Asserting reset mid-stream discards that cycle's result; there is no other state.
- No stall or flush inputs: the outputs update every non-reset edge.

Optional Feature:
- Macro: EXEC_MUL_EN.
- Defined: R-type (ALUOp 10) with funct7 = 0000001 selects the M-extension multiply, by funct3:
  - 000 MUL: low 32 bits of A*B.
  - 001 MULH: high 32 bits, signed x signed.
  - 010 MULHSU: high 32 bits, signed A x unsigned B.
  - 011 MULHU: high 32 bits, unsigned x unsigned.
  - 100-111: result 0.
  - Still single-cycle, registered like other ops.
- Undefined: no multiplier is instantiated. funct7 = 0000001 decodes as the base op with funct7[5]=0, e.g. funct3 000 -> ADD.

Test Plan:
- Reset: rst=0 for 2 edges with A=10, B=20, ALUOp=10 -> ALU_Result=0, Zero=0. Release rst -> next edge ALU_Result=30, Zero=0.
- R-type ALUOp=10, A=10, reg_data2=20, imm=100, select_imm=0: ADD -> 30. funct7=0100000 -> 0xFFFFFFF6 (-10). funct3=111 AND -> 0 with Zero=1. funct3=110 OR -> 30.
- Immediate: select_imm=1, ALUOp=00, funct3=000, A=10, imm=100 -> 110. ALUOp=10, funct3=010, A=-5, imm=4 -> SLT result 1. funct3=011 (SLTU) -> 0.
- Shifts: A=0x80000000, imm=4, ALUOp=11, funct3=101: funct7=0100000 -> 0xF8000000; funct7=0 -> 0x08000000. funct3=001 with A=1, imm=31 -> 0x80000000.
- Branch: ALUOp=01, A=B=7 -> result 0, Zero=1. A=7, B=8 -> 0xFFFFFFFF, Zero=0. ADD 0xFFFFFFFF+1 -> 0, Zero=1 (wrap).
- EXEC_MUL_EN: A=-3, B=5, funct7=0000001, funct3=000 -> 0xFFFFFFF1; funct3=001 -> 0xFFFFFFFF. Without the macro, the same stimulus at funct3=000 -> 2 (ADD).
